// File: rtl/thor2024_stack_expander_pkg.sv
// Shared types and constants for the Thor2024 stack micro-op expander.
package thor2024_stack_expander_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_NOP   = 7'h00;
  localparam opcode_t OP_ADD   = 7'h02;
  localparam opcode_t OP_ADDI  = 7'h04;
  localparam opcode_t OP_STO   = 7'h10;
  localparam opcode_t OP_LDO   = 7'h11;
  localparam opcode_t OP_PUSH  = 7'h20;
  localparam opcode_t OP_POP   = 7'h21;
  localparam opcode_t OP_ENTER = 7'h22;
  localparam opcode_t OP_LEAVE = 7'h23;
  localparam opcode_t OP_PFX   = 7'h30;
  localparam opcode_t OP_ATOM  = 7'h31;

  localparam logic [4:0] REG_SP = 5'd31;
  localparam logic [4:0] REG_FP = 5'd30;
  localparam logic [4:0] REG_LR = 5'd29;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_EXPAND = 1'b1;

  // Decoded instruction. For ordinary instructions regs[0..2] are rd/ra/rs and
  // imm16 is sign-extended; stack ops use regs[0..3] as R0..R3, cnt as N-1 and
  // imm16 as an unsigned byte count.
  typedef struct packed {
    opcode_t          opcode;
    logic [1:0]       cnt;
    logic [3:0][4:0]  regs;
    logic [15:0]      imm16;
  } instruction_t;

  // Micro-op. STO stores rs to [ra+imm]; LDO loads rd from [ra+imm];
  // ADDI writes rd = ra + imm.
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rs;
    logic [63:0] imm;
    logic        last;
    logic [63:0] pc;
  } uop_t;

  function automatic logic is_stack_op(input opcode_t op);
    return (op == OP_PUSH) || (op == OP_POP) || (op == OP_ENTER) || (op == OP_LEAVE);
  endfunction

endpackage

// File: rtl/thor2024_stack_expander_uop_gen.sv
// Combinational micro-op generator: (instruction, idx) -> micro-op and last flag.
module thor2024_stack_uop_gen
  import thor2024_stack_expander_pkg::*;
(
  input  instruction_t i_instr,
  input  logic [63:0]  i_pc,
  input  logic [2:0]   i_idx,
  output uop_t         o_uop,
  output logic         o_last
);

  logic [2:0]  w_n;
  logic [63:0] w_n8;
  logic [63:0] w_imm;
  logic [1:0]  w_k_push;
  logic [63:0] w_off_push;
  logic [63:0] w_off_pop;

  assign w_n        = {1'b0, i_instr.cnt} + 3'd1;
  assign w_n8       = {58'd0, w_n, 3'b000};
  assign w_imm      = {48'd0, i_instr.imm16};
  // PUSH emits its SP adjust first, so store k sits at idx k+1.
  assign w_k_push   = i_idx[1:0] - 2'd1;
  assign w_off_push = {59'd0, w_k_push, 3'b000};
  assign w_off_pop  = {59'd0, i_idx[1:0], 3'b000};
  assign o_last     = o_uop.last;

  // Select the micro-op for the current step of the sequence.
  always_comb begin
    o_uop      = '0;
    o_uop.pc   = i_pc;
    o_uop.last = 1'b1;
    case (i_instr.opcode)
      OP_PUSH: begin
        if (i_idx == 3'd0) begin
          o_uop.opcode = OP_ADDI;
          o_uop.rd     = REG_SP;
          o_uop.ra     = REG_SP;
          o_uop.imm    = 64'd0 - w_n8;
          o_uop.last   = 1'b0;
        end else begin
          o_uop.opcode = OP_STO;
          o_uop.ra     = REG_SP;
          o_uop.rs     = i_instr.regs[w_k_push];
          o_uop.imm    = w_off_push;
          o_uop.last   = (i_idx == w_n);
        end
      end
      OP_POP: begin
        if (i_idx == w_n) begin
          o_uop.opcode = OP_ADDI;
          o_uop.rd     = REG_SP;
          o_uop.ra     = REG_SP;
          o_uop.imm    = w_n8;
        end else begin
          o_uop.opcode = OP_LDO;
          o_uop.rd     = i_instr.regs[i_idx[1:0]];
          o_uop.ra     = REG_SP;
          o_uop.imm    = w_off_pop;
          o_uop.last   = 1'b0;
        end
      end
      OP_ENTER: begin
        case (i_idx)
          3'd0: begin
            o_uop.opcode = OP_STO;
            o_uop.ra     = REG_SP;
            o_uop.rs     = REG_FP;
            o_uop.imm    = 64'd0 - 64'd16;
            o_uop.last   = 1'b0;
          end
          3'd1: begin
            o_uop.opcode = OP_STO;
            o_uop.ra     = REG_SP;
            o_uop.rs     = REG_LR;
            o_uop.imm    = 64'd0 - 64'd8;
            o_uop.last   = 1'b0;
          end
          3'd2: begin
            o_uop.opcode = OP_ADDI;
            o_uop.rd     = REG_FP;
            o_uop.ra     = REG_SP;
            o_uop.imm    = 64'd0 - 64'd16;
            o_uop.last   = 1'b0;
          end
          default: begin
            o_uop.opcode = OP_ADDI;
            o_uop.rd     = REG_SP;
            o_uop.ra     = REG_SP;
            o_uop.imm    = 64'd0 - (64'd16 + w_imm);
          end
        endcase
      end
      OP_LEAVE: begin
        case (i_idx)
          3'd0: begin
            o_uop.opcode = OP_LDO;
            o_uop.rd     = REG_LR;
            o_uop.ra     = REG_FP;
            o_uop.imm    = 64'd8;
            o_uop.last   = 1'b0;
          end
          3'd1: begin
            o_uop.opcode = OP_ADDI;
            o_uop.rd     = REG_SP;
            o_uop.ra     = REG_FP;
            o_uop.imm    = 64'd16 + w_imm;
            o_uop.last   = 1'b0;
          end
          default: begin
            o_uop.opcode = OP_LDO;
            o_uop.rd     = REG_FP;
            o_uop.ra     = REG_FP;
          end
        endcase
      end
      default: begin
        o_uop.opcode = i_instr.opcode;
        o_uop.rd     = i_instr.regs[0];
        o_uop.ra     = i_instr.regs[1];
        o_uop.rs     = i_instr.regs[2];
        o_uop.imm    = {{48{i_instr.imm16[15]}}, i_instr.imm16};
      end
    endcase
  end

endmodule

// File: rtl/thor2024_stack_expander.sv
// Stack micro-op expander: splits PUSH/POP/ENTER/LEAVE into ADDI/STO/LDO
// micro-ops, passes other instructions through and drops NOPs.
module thor2024_stack_expander
  import thor2024_stack_expander_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  instruction_t in_instr,
  input  logic [63:0]  in_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output uop_t         out_uop
);

  logic [0:0]   r_state;
  logic [2:0]   r_idx;
  instruction_t r_instr;
  logic [63:0]  r_pc;
  logic         r_out_valid;
  uop_t         r_out_uop;

  logic         w_idle;
  logic         w_xfer;
  logic         w_can_load;
  logic         w_accept;
  logic         w_is_nop;
  logic         w_is_stack;
  instruction_t w_gen_instr;
  logic [63:0]  w_gen_pc;
  logic [2:0]   w_gen_idx;
  uop_t         w_gen_uop;
  logic         w_gen_last;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_xfer     = r_out_valid && out_ready;
  assign w_can_load = !r_out_valid || out_ready;
  assign in_ready   = !flush && w_idle && w_can_load;
  assign w_accept   = in_valid && in_ready;
  assign w_is_nop   = (in_instr.opcode == OP_NOP);
  assign w_is_stack = is_stack_op(in_instr.opcode);

  // EXPAND means micro-ops remain beyond the one held in the output register,
  // so the FSM drops back to IDLE as soon as the last one is loaded; that is
  // what lets the next instruction be taken alongside the final transfer.
  assign w_gen_instr = w_idle ? in_instr : r_instr;
  assign w_gen_pc    = w_idle ? in_pc    : r_pc;
  assign w_gen_idx   = w_idle ? 3'd0     : r_idx + 3'd1;

  thor2024_stack_uop_gen u_gen (
    .i_instr (w_gen_instr),
    .i_pc    (w_gen_pc),
    .i_idx   (w_gen_idx),
    .o_uop   (w_gen_uop),
    .o_last  (w_gen_last)
  );

  assign out_valid = r_out_valid;
  assign out_uop   = r_out_uop;

  // FSM, latched instruction and registered micro-op output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_out_valid <= 1'b0;
      r_out_uop   <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else if (w_idle) begin
      if (w_accept) begin
        if (w_is_nop) begin
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= 1'b1;
          r_out_uop   <= w_gen_uop;
        end
        if (w_is_stack) begin
          r_instr <= in_instr;
          r_pc    <= in_pc;
          r_idx   <= '0;
          r_state <= w_gen_last ? ST_IDLE : ST_EXPAND;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end else if (w_xfer) begin
      r_out_uop <= w_gen_uop;
      r_idx     <= w_gen_idx;
      if (w_gen_last) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_thor2024_stack_expander.sv
// Self-checking bench for thor2024_stack_expander: directed steps plus random
// traffic, scored against a queue-based model of the expected micro-op stream.
module tb_thor2024_stack_expander;
  import thor2024_stack_expander_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  instruction_t in_instr = '0;
  logic [63:0]  in_pc = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  uop_t         out_uop;

  always #5 clk = ~clk;

  thor2024_stack_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uop   (out_uop)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  uop_t         exp_q[$];
  uop_t         log_q[$];
  logic         exp_valid = 1'b0;
  logic         p_stall = 1'b0;
  uop_t         p_uop = '0;
  instruction_t idle_i = '0;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input uop_t obs, input uop_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed op=%h rd=%0d ra=%0d rs=%0d imm=%h last=%b pc=%h expected op=%h rd=%0d ra=%0d rs=%0d imm=%h last=%b pc=%h",
             tag, obs.opcode, obs.rd, obs.ra, obs.rs, obs.imm, obs.last, obs.pc,
             exp.opcode, exp.rd, exp.ra, exp.rs, exp.imm, exp.last, exp.pc);
    end
  endtask

  function automatic instruction_t mkins(input opcode_t op, input logic [1:0] cnt,
                                         input logic [4:0] r0, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] r3,
                                         input logic [15:0] imm16);
    instruction_t i;
    i.opcode  = op;
    i.cnt     = cnt;
    i.regs[0] = r0;
    i.regs[1] = r1;
    i.regs[2] = r2;
    i.regs[3] = r3;
    i.imm16   = imm16;
    return i;
  endfunction

  function automatic uop_t mk(input opcode_t op, input logic [4:0] rd, input logic [4:0] ra,
                              input logic [4:0] rs, input logic [63:0] imm, input logic last,
                              input logic [63:0] pc);
    uop_t u;
    u.opcode = op;
    u.rd     = rd;
    u.ra     = ra;
    u.rs     = rs;
    u.imm    = imm;
    u.last   = last;
    u.pc     = pc;
    return u;
  endfunction

  // Expected micro-op list for one accepted instruction.
  function automatic void model(input instruction_t ins, input logic [63:0] pc);
    int unsigned n;
    logic [63:0] ib;
    n  = int'(ins.cnt) + 1;
    ib = 64'(ins.imm16);
    case (ins.opcode)
      OP_NOP: ;
      OP_PUSH: begin
        exp_q.push_back(mk(OP_ADDI, 5'd31, 5'd31, 5'd0, -64'(8 * n), 1'b0, pc));
        for (int unsigned k = 0; k < n; k++)
          exp_q.push_back(mk(OP_STO, 5'd0, 5'd31, ins.regs[k], 64'(8 * k), k == n - 1, pc));
      end
      OP_POP: begin
        for (int unsigned k = 0; k < n; k++)
          exp_q.push_back(mk(OP_LDO, ins.regs[k], 5'd31, 5'd0, 64'(8 * k), 1'b0, pc));
        exp_q.push_back(mk(OP_ADDI, 5'd31, 5'd31, 5'd0, 64'(8 * n), 1'b1, pc));
      end
      OP_ENTER: begin
        exp_q.push_back(mk(OP_STO,  5'd0,  5'd31, 5'd30, -64'd16, 1'b0, pc));
        exp_q.push_back(mk(OP_STO,  5'd0,  5'd31, 5'd29, -64'd8,  1'b0, pc));
        exp_q.push_back(mk(OP_ADDI, 5'd30, 5'd31, 5'd0,  -64'd16, 1'b0, pc));
        exp_q.push_back(mk(OP_ADDI, 5'd31, 5'd31, 5'd0,  -(64'd16 + ib), 1'b1, pc));
      end
      OP_LEAVE: begin
        exp_q.push_back(mk(OP_LDO,  5'd29, 5'd30, 5'd0, 64'd8,        1'b0, pc));
        exp_q.push_back(mk(OP_ADDI, 5'd31, 5'd30, 5'd0, 64'd16 + ib,  1'b0, pc));
        exp_q.push_back(mk(OP_LDO,  5'd30, 5'd30, 5'd0, 64'd0,        1'b1, pc));
      end
      default:
        exp_q.push_back(mk(ins.opcode, ins.regs[0], ins.regs[1], ins.regs[2],
                           {{48{ins.imm16[15]}}, ins.imm16}, 1'b1, pc));
    endcase
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later, score.
  task automatic cyc(input logic v, input instruction_t ins, input logic [63:0] pc,
                     input logic ordy, input logic fl);
    logic exp_rdy;
    logic acc;
    uop_t u;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && (exp_q.size() == 0 || (exp_q.size() == 1 && ordy));
    chk64("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk64("out_valid", 64'(out_valid), 64'(exp_valid));
    if (p_stall && out_valid) chk_uop("stall_hold", out_uop, p_uop);
    if (out_valid && ordy && exp_q.size() != 0) begin
      u = exp_q.pop_front();
      chk_uop("uop", out_uop, u);
      log_q.push_back(out_uop);
    end
    acc     = v && in_ready;
    p_stall = out_valid && !ordy && !fl;
    p_uop   = out_uop;
    if (fl) exp_q.delete();
    else if (acc) model(ins, pc);
    exp_valid = (exp_q.size() != 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, idle_i, 64'd0, 1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic mid_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk64("rst_out_valid", 64'(out_valid), 64'd0);
    chk_uop("rst_out_uop", out_uop, '0);
    exp_q.delete();
    exp_valid = 1'b0;
    p_stall   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  opcode_t ops[10] = '{OP_NOP, OP_ADD, OP_ADDI, OP_STO, OP_PFX, OP_ATOM,
                       OP_PUSH, OP_POP, OP_ENTER, OP_LEAVE};

  initial begin
    instruction_t ri;
    logic         rv, rr, rf;
    int unsigned  pat;

    mid_reset();
    idle(1);

    // PUSH r3,r4,r5 (cnt=2)
    log_q.delete();
    cyc(1'b1, mkins(OP_PUSH, 2'd2, 5'd3, 5'd4, 5'd5, 5'd9, 16'h0), 64'h400, 1'b1, 1'b0);
    idle(4);
    chk64("push_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk64("push_sp_adj", log_q[0].imm, 64'hFFFF_FFFF_FFFF_FFE8);
      chk64("push_st2_off", log_q[3].imm, 64'd16);
      chk64("push_st2_reg", 64'(log_q[3].rs), 64'd5);
    end

    // ENTER 0x20
    log_q.delete();
    cyc(1'b1, mkins(OP_ENTER, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0020), 64'h1000, 1'b1, 1'b0);
    idle(4);
    chk64("enter_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      chk64("enter_frame", log_q[3].imm, 64'hFFFF_FFFF_FFFF_FFD0);
      for (int i = 0; i < 4; i++) chk64("enter_pc", log_q[i].pc, 64'h1000);
    end

    // NOP, ADD, NOP, ATOM back to back
    log_q.delete();
    cyc(1'b1, mkins(OP_NOP,  2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0001), 64'h2000, 1'b1, 1'b0);
    cyc(1'b1, mkins(OP_ADD,  2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h8001), 64'h2004, 1'b1, 1'b0);
    cyc(1'b1, mkins(OP_NOP,  2'd0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0002), 64'h2008, 1'b1, 1'b0);
    cyc(1'b1, mkins(OP_ATOM, 2'd3, 5'd7, 5'd8, 5'd9, 5'd0, 16'h1234), 64'h200C, 1'b1, 1'b0);
    idle(2);
    chk64("stream_count", 64'(log_q.size()), 64'd2);

    // POP cnt=3 with out_ready 1,0,0,1,0,0,...
    log_q.delete();
    cyc(1'b1, mkins(OP_POP, 2'd3, 5'd10, 5'd11, 5'd12, 5'd13, 16'h0), 64'h3000, 1'b1, 1'b0);
    pat = 0;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      cyc(1'b0, idle_i, 64'd0, (pat % 3) == 0, 1'b0);
      pat++;
    end
    chk64("pop_count", 64'(log_q.size()), 64'd5);

    // LEAVE flushed while its second micro-op is on the output
    cyc(1'b1, mkins(OP_LEAVE, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0010), 64'h4000, 1'b1, 1'b0);
    cyc(1'b0, idle_i, 64'd0, 1'b1, 1'b0);
    cyc(1'b1, mkins(OP_ADD, 2'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0), 64'h4004, 1'b0, 1'b1);
    cyc(1'b0, idle_i, 64'd0, 1'b1, 1'b0);
    chk64("flush_ready", 64'(in_ready), 64'd1);
    log_q.delete();
    cyc(1'b1, mkins(OP_ADD, 2'd0, 5'd2, 5'd3, 5'd4, 5'd0, 16'h0005), 64'h4008, 1'b1, 1'b0);
    idle(1);
    chk64("flush_then_add", 64'(log_q.size()), 64'd1);

    // Reset in the middle of a PUSH
    cyc(1'b1, mkins(OP_PUSH, 2'd3, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0), 64'h5000, 1'b1, 1'b0);
    cyc(1'b0, idle_i, 64'd0, 1'b1, 1'b0);
    mid_reset();
    log_q.delete();
    cyc(1'b1, mkins(OP_PUSH, 2'd0, 5'd7, 5'd0, 5'd0, 5'd0, 16'h0), 64'h5004, 1'b1, 1'b0);
    idle(2);
    chk64("post_rst_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() != 0) chk64("post_rst_first", log_q[0].imm, 64'hFFFF_FFFF_FFFF_FFF8);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ri = mkins(ops[$urandom % 10], 2'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), 5'($urandom), 16'($urandom));
      rv = ($urandom % 4) != 0;
      rr = ($urandom % 4) != 0;
      rf = ($urandom % 50) == 0;
      cyc(rv, ri, {32'h0, $urandom}, rr, rf);
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    chk64("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
